vram_arbiter: RTL
=================

# vram_arbiter

Arbiter and sequencer for the single-port video RAM that feeds the VGA scan-out. It shares the RAM between the VGA reader and a host port that writes pixel data and reads it back. The VGA reader has absolute priority whenever it requests. Host accesses are buffered in a small in-order queue and drained in free cycles, mainly horizontal and vertical blanking.

## Interface
Parameters:
- AW, 8, RAM address width (matches the VGA `vaddr` width)
- DW, 8, RAM data width (matches the VGA `vdata` width)
- QDEPTH, 4, host request queue depth; must be a power of two, at least 2

Ports:
- clk  in  1  single clock for the whole block
- reset  in  1  asynchronous, active-low reset
- vid_req  in  1  VGA needs a RAM read this cycle (display-area qualifier)
- vid_addr  in  AW  VGA read address
- vid_data  out  DW  VGA read data, registered
- host_valid  in  1  host request present
- host_ready  out  1  queue can accept a request
- host_we  in  1  1 = write, 0 = read
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_rvalid  out  1  one-cycle pulse when host_rdata is valid
- host_rdata  out  DW  host read data
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  synchronous RAM read data, one cycle after mem_en with mem_we = 0
- q_count  out  $clog2(QDEPTH+1)  current number of queued host requests

## Operation
- **Queue.** Circular FIFO with QDEPTH entries; each entry holds {we, addr, wdata}.
  - A request is accepted on a cycle where host_valid and host_ready are both 1.
  - host_ready = (q_count < QDEPTH). It is computed from registered state only and never depends on vid_req.
- **Per-cycle grant.** The grant is combinational from the current inputs and queue state, with the following priority:
  - **GNT_VID** when vid_req = 1: mem_en = 1, mem_we = 0, mem_addr = vid_addr.
  - **GNT_HOST** when vid_req = 0 and the queue is not empty: the head entry is popped and driven onto the mem_* outputs.
  - **GNT_NONE** otherwise: mem_en = 0, mem_we = 0, and mem_addr/mem_wdata hold their last values.
- **Grant tracking.** A 2-bit registered tag records the previous cycle's grant: NONE, VID, HRD (host read) or HWR (host write).
- **Read return.**
  - Tag = VID: vid_data <= mem_rdata.
  - Tag = HRD: host_rdata <= mem_rdata and host_rvalid pulses for one cycle.
  - Otherwise vid_data and host_rdata hold their values and host_rvalid = 0.
- **Ordering.** Host requests complete strictly in acceptance order. A read issued after a write to the same address returns the new data.
- **Simultaneous push and pop.** Both are allowed in the same cycle; q_count is unchanged. A push can only occur while not full, so overflow is impossible.
- **Empty queue.** A push into an empty queue becomes visible at the head the next cycle; there is no same-cycle bypass.
- **Pointers.** Read and write pointers are log2(QDEPTH) bits and wrap modulo QDEPTH.
- **Reset (asynchronous, reset low).**
  - Queue is flushed, pointers = 0, q_count = 0, tag = NONE.
  - Outputs: vid_data = 0, host_rdata = 0, host_rvalid = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - host_ready = 0 while reset is low and 1 from the first cycle after release.
  - A reset in the middle of a host read drops the pending host_rvalid.

## Timing
- **VGA latency.** vid_addr is presented at cycle N. The RAM returns data at N+1, and vid_data is registered at the N+2 edge, giving 2 cycles total.
- **Host read latency.** With the queue empty and vid_req = 0, a read accepted at cycle N:
  - is issued at N+1;
  - appears on host_rdata with host_rvalid = 1 at N+3.
- **Host write latency.** A write accepted at cycle N is driven on mem_* at N+1 at the earliest.
- **Stalls.** Host issue is delayed one cycle for every cycle vid_req is 1. There is no fairness limit, so the host starves for the full active line (640 cycles) and drains in blanking (160 cycles per line).

## Structure
- **Package `vram_pkg`:**
  - grant tag enum: GNT_NONE, GNT_VID, GNT_HRD, GNT_HWR;
  - packed queue entry struct: {we, addr, wdata};
  - default AW/DW constants.
- **Sub-module `vram_req_fifo`:**
  - parameterised FIFO for queue entries;
  - ports: push, pop, head, count, full, empty.
- **Top level** holds the grant logic, tag register and read-return registers.

## Test plan
- **Reset values.** Assert reset mid-stream with 3 entries queued → q_count = 0, host_ready = 0, all mem_* = 0. After release, host_ready = 1 and no stale host_rvalid.
- **Host-only read-after-write.** vid_req = 0; write addr 0x85 = 0x2A, then read 0x85 → host_rvalid at the required cycle with host_rdata = 0x2A, and exactly one mem write precedes the read.
- **VGA priority.** vid_req = 1 for 20 cycles with 4 host writes pending → no host mem access during those 20 cycles and host_ready = 0 while full. Writes drain on 4 consecutive cycles after vid_req falls.
- **VGA latency.** vid_addr sweeps 0x80..0x87 over RAM preloaded with data = addr → vid_data equals each address exactly 2 cycles later.
- **Queue wrap and concurrent push/pop.** 10 back-to-back host accesses with vid_req toggling every cycle → pointers wrap, q_count never exceeds 4, and results match in order.
- **Full boundary.** Hold host_valid with vid_req = 1 → exactly QDEPTH requests are accepted, then host_ready = 0 until the first pop.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: grant tags, the host queue entry and default widths.
// Imported by the interface, the request FIFO and the arbiter top level.
package vram_pkg;

    localparam int VRAM_AW = 8;
    localparam int VRAM_DW = 8;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_HRD  = 2'd2,
        GNT_HWR  = 2'd3
    } grant_e;

    // Queue entries are sized from the package widths; override AW/DW together with these.
    typedef struct packed {
        logic               we;
        logic [VRAM_AW-1:0] addr;
        logic [VRAM_DW-1:0] wdata;
    } vram_entry_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of the VGA read port, host request port and RAM port around the VRAM arbiter.
// The arbiter uses the slave view; the surrounding system (or bench) uses the master view.
interface vram_arbiter_if #(
    parameter int AW     = vram_pkg::VRAM_AW,
    parameter int DW     = vram_pkg::VRAM_DW,
    parameter int QDEPTH = 4
) ();

    localparam int CW = $clog2(QDEPTH + 1);

    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;

    logic          host_valid;
    logic          host_ready;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [CW-1:0] q_count;

    modport slave (
        input  vid_req, vid_addr, host_valid, host_we, host_addr, host_wdata, mem_rdata,
        output vid_data, host_ready, host_rvalid, host_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, q_count
    );

    modport master (
        output vid_req, vid_addr, host_valid, host_we, host_addr, host_wdata, mem_rdata,
        input  vid_data, host_ready, host_rvalid, host_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, q_count
    );

endinterface

// File: rtl/vram_req_fifo.sv
// In-order circular queue of host requests; head is the oldest entry, no same-cycle bypass.
// DEPTH must be a power of two so the pointers wrap naturally.
module vram_req_fifo
    import vram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  vram_entry_t                  data_i,
    input  logic                         pop_i,
    output vram_entry_t                  head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    vram_entry_t   entries_q [DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic          pushOk;
    logic          popOk;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pushOk  = push_i && !full_o;
    assign popOk   = pop_i && !empty_o;
    assign head_o  = entries_q[rdPtr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (popOk) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            count_q <= count_q + CW'(pushOk) - CW'(popOk);
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            entries_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA reads always win, host requests drain from an in-order queue
// in free cycles, and read data is steered back by a one-cycle-delayed grant tag.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW     = VRAM_AW,
    parameter int DW     = VRAM_DW,
    parameter int QDEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    vram_arbiter_if.slave  bus
);

    localparam int CW = $clog2(QDEPTH + 1);

    grant_e        grant;
    grant_e        tag_q;
    logic          active_q;
    vram_entry_t   pushEntry;
    vram_entry_t   head;
    logic [CW-1:0] fifoCount;
    logic          fifoFull;
    logic          fifoEmpty;
    logic          push;
    logic          pop;
    logic [AW-1:0] memAddr_d;
    logic [AW-1:0] memAddr_q;
    logic [DW-1:0] memWdata_d;
    logic [DW-1:0] memWdata_q;
    logic [DW-1:0] vidData_q;
    logic [DW-1:0] hostRdata_q;
    logic          hostRvalid_q;

    // active_q keeps the RAM port and host_ready quiet until the first edge after reset.
    assign bus.host_ready = active_q && !fifoFull;
    assign push           = bus.host_valid && bus.host_ready;
    assign pop            = (grant == GNT_HRD) || (grant == GNT_HWR);
    assign pushEntry      = '{we: bus.host_we, addr: bus.host_addr, wdata: bus.host_wdata};

    vram_req_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (pushEntry),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (fifoCount),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    always_comb begin
        grant      = GNT_NONE;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        if (active_q) begin
            if (bus.vid_req) begin
                grant     = GNT_VID;
                memAddr_d = bus.vid_addr;
            end else if (!fifoEmpty) begin
                grant      = head.we ? GNT_HWR : GNT_HRD;
                memAddr_d  = head.addr;
                memWdata_d = head.wdata;
            end
        end
    end

    assign bus.mem_en      = (grant != GNT_NONE);
    assign bus.mem_we      = (grant == GNT_HWR);
    assign bus.mem_addr    = memAddr_d;
    assign bus.mem_wdata   = memWdata_d;
    assign bus.q_count     = fifoCount;
    assign bus.vid_data    = vidData_q;
    assign bus.host_rdata  = hostRdata_q;
    assign bus.host_rvalid = hostRvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q     <= 1'b0;
            tag_q        <= GNT_NONE;
            memAddr_q    <= '0;
            memWdata_q   <= '0;
            vidData_q    <= '0;
            hostRdata_q  <= '0;
            hostRvalid_q <= 1'b0;
        end else begin
            active_q     <= 1'b1;
            tag_q        <= grant;
            memAddr_q    <= memAddr_d;
            memWdata_q   <= memWdata_d;
            hostRvalid_q <= (tag_q == GNT_HRD);
            if (tag_q == GNT_VID) begin
                vidData_q <= bus.mem_rdata;
            end
            if (tag_q == GNT_HRD) begin
                hostRdata_q <= bus.mem_rdata;
            end
        end
    end

endmodule
